// File: rtl/pdm_pkg.sv
// Shared PDM defaults: sample width, oversampling ratio, silence level, edge classification.
// Latency: n/a (constants and a combinational helper only).
// Backpressure: n/a.
package pdm_pkg;

  localparam int PDM_SAMPLE_W   = 16;
  localparam int PDM_OSR        = 128;
  localparam int PDM_FIFO_DEPTH = 4;

  // Offset-binary midpoint: 50% pulse density.
  localparam logic [PDM_SAMPLE_W-1:0] PDM_SILENCE = {1'b1, {(PDM_SAMPLE_W-1){1'b0}}};

  typedef enum logic [1:0] {
    EV_NONE    = 2'd0,
    EV_DRIVE   = 2'd1,
    EV_RELEASE = 2'd2
  } pdm_ev_e;

  // Left channel drives on the rising bit-clock edge, right channel on the falling edge.
  function automatic pdm_ev_e pdm_edge_event(input logic rise, input logic fall, input logic lr_sel);
    pdm_ev_e ev;
    ev = EV_NONE;
    if (lr_sel ? fall : rise) ev = EV_DRIVE;
    else if (lr_sel ? rise : fall) ev = EV_RELEASE;
    return ev;
  endfunction

endpackage

// File: rtl/pdm_sample_fifo.sv
// Synchronous FIFO holding PCM samples between the host and the modulator.
// Latency: a pushed entry is visible on data/empty the cycle after the push.
// Backpressure: full blocks further pushes; pops while empty are ignored.
module pdm_sample_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] data
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign data    = mem[rd_ptr];

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  // Pointers and occupancy; a simultaneous push and pop leaves count unchanged.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/pdm_mic_emu.sv
// PDM microphone emulator: first-order sigma-delta modulation of buffered PCM samples onto m_data.
// Latency: m_data/m_data_oe update 3 clk after the raw m_clk transition (2-FF sync + delay reg).
// Backpressure: s_ready drops while the sample FIFO is full; one sample is popped per OSR bits.
module pdm_mic_emu
  import pdm_pkg::*;
#(
  parameter int SAMPLE_W   = PDM_SAMPLE_W,
  parameter int OSR        = PDM_OSR,
  parameter int FIFO_DEPTH = PDM_FIFO_DEPTH
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [SAMPLE_W-1:0] s_data,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic                m_clk,
  input  logic                m_lr_sel,
  output logic                m_data,
  output logic                m_data_oe,
  output logic                underflow,
  input  logic                underflow_clr
);

  localparam int CNT_W = $clog2(OSR);
  localparam logic [SAMPLE_W-1:0] SILENCE = {1'b1, {(SAMPLE_W-1){1'b0}}};

  logic [2:0]          mclk_sync;   // [0],[1] synchronizer, [2] delay for edge detect
  logic                mclk_rise;
  logic                mclk_fall;
  pdm_ev_e             ev;
  logic                drive;
  logic                wrap;
  logic [SAMPLE_W-1:0] acc;
  logic [SAMPLE_W-1:0] cur_sample;
  logic [SAMPLE_W:0]   sum;
  logic [CNT_W-1:0]    bit_cnt;
  logic                ready_en;
  logic                fifo_full;
  logic                fifo_empty;
  logic [SAMPLE_W-1:0] fifo_data;
  logic                push;
  logic                pop;

  assign mclk_rise = mclk_sync[1] & ~mclk_sync[2];
  assign mclk_fall = ~mclk_sync[1] & mclk_sync[2];
  assign ev        = pdm_edge_event(mclk_rise, mclk_fall, m_lr_sel);
  assign drive     = (ev == EV_DRIVE);
  assign wrap      = drive && (bit_cnt == CNT_W'(OSR-1));
  assign sum       = {1'b0, acc} + {1'b0, cur_sample};

  // Empty FIFO at the wrap is an underflow: no bypass of a same-cycle push.
  assign pop     = wrap && !fifo_empty;
  assign s_ready = ready_en && !fifo_full;
  assign push    = s_valid && s_ready;

  pdm_sample_fifo #(
    .WIDTH (SAMPLE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (s_data),
    .pop       (pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .data      (fifo_data)
  );

  // Bring the master bit clock into the clk domain and keep one delayed copy.
  always_ff @(posedge clk) begin
    if (!rst_n) mclk_sync <= '0;
    else        mclk_sync <= {mclk_sync[1:0], m_clk};
  end

  // Hold s_ready low for the first cycle after reset release.
  always_ff @(posedge clk) begin
    if (!rst_n) ready_en <= 1'b0;
    else        ready_en <= 1'b1;
  end

  // Modulator: accumulate on each drive edge, emit the carry, reload the sample on the wrap.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc        <= '0;
      cur_sample <= SILENCE;
      bit_cnt    <= '0;
      m_data     <= 1'b0;
      m_data_oe  <= 1'b0;
    end else if (drive) begin
      acc       <= sum[SAMPLE_W-1:0];
      m_data    <= sum[SAMPLE_W];
      m_data_oe <= 1'b1;
      bit_cnt   <= wrap ? '0 : bit_cnt + CNT_W'(1);
      if (pop) cur_sample <= fifo_data;
    end else if (ev == EV_RELEASE) begin
      m_data_oe <= 1'b0;
    end
  end

  // Sticky underflow flag; a set in the same cycle as a clear wins.
  always_ff @(posedge clk) begin
    if (!rst_n)                  underflow <= 1'b0;
    else if (wrap && fifo_empty) underflow <= 1'b1;
    else if (underflow_clr)      underflow <= 1'b0;
  end

endmodule

// File: tb/tb_pdm_mic_emu.sv
// Scoreboard bench for pdm_mic_emu: expected per-window densities are queued by the stimulus,
// a negedge monitor counts emitted bits and checks drive/release latency against raw m_clk edges.
module tb_pdm_mic_emu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] s_data = '0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic        m_clk = 1'b0;
  logic        m_lr_sel = 1'b0;
  logic        m_data;
  logic        m_data_oe;
  logic        underflow;
  logic        underflow_clr = 1'b0;

  pdm_mic_emu dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .s_data        (s_data),
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .m_clk         (m_clk),
    .m_lr_sel      (m_lr_sel),
    .m_data        (m_data),
    .m_data_oe     (m_data_oe),
    .underflow     (underflow),
    .underflow_clr (underflow_clr)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // m_clk generator: toggles every half_p clk, 3 ns after a clk rise; records raw edge cycles.
  int half_p = 20;
  bit mclk_run = 1'b0;
  int div = 0;
  int rise_cyc = -100;
  int fall_cyc = -100;

  initial begin
    forever begin
      @(posedge clk);
      #3;
      if (mclk_run) begin
        div++;
        if (div >= half_p) begin
          div = 0;
          m_clk = ~m_clk;
          if (m_clk) rise_cyc = cyc;
          else       fall_cyc = cyc;
        end
      end
    end
  end

  // Scoreboard: expected ones per 128-bit window plus underflow mid-window and at the wrap.
  typedef struct {
    int ones;
    bit uf_mid;
    bit uf_end;
  } win_t;
  win_t exp_q[$];

  function automatic win_t mk(input int ones, input bit uf_mid, input bit uf_end);
    win_t w;
    w.ones = ones;
    w.uf_mid = uf_mid;
    w.uf_end = uf_end;
    return w;
  endfunction

  // Monitor
  int   bits = 0;
  int   ones = 0;
  logic prev_oe = 1'b0;
  logic prev_md = 1'b0;
  logic prev_rst = 1'b0;

  always @(negedge clk) begin
    logic oe_rise;
    logic oe_fall;
    win_t w;
    oe_rise = m_data_oe && !prev_oe;
    oe_fall = !m_data_oe && prev_oe;
    if (!rst_n) begin
      bits = 0;
      ones = 0;
    end else if (prev_rst) begin
      if (oe_rise) begin
        chk("drive_latency", cyc - (m_lr_sel ? fall_cyc : rise_cyc), 3);
        bits++;
        ones += int'(m_data);
        if (exp_q.size() > 0) begin
          if (bits % 128 == 64) chk("underflow_mid_window", underflow, exp_q[0].uf_mid);
          if (bits % 128 == 0) begin
            w = exp_q.pop_front();
            chk("window_ones", ones, w.ones);
            chk("underflow_at_wrap", underflow, w.uf_end);
          end
        end
        if (bits % 128 == 0) ones = 0;
      end else if (oe_fall) begin
        chk("release_latency", cyc - (m_lr_sel ? rise_cyc : fall_cyc), 3);
      end
      if (m_data !== prev_md) chk("data_changes_only_on_drive", oe_rise, 1);
    end
    prev_oe = m_data_oe;
    prev_md = m_data;
    prev_rst = rst_n;
  end

  task automatic wait_bits(input int n);
    int t = 0;
    while (bits < n && t < 20000) begin
      @(negedge clk);
      t++;
    end
    chk("bit_count_reached", (bits >= n), 1);
  endtask

  task automatic pause_low();
    int t = 0;
    while (m_clk && t < 200) begin
      @(posedge clk);
      t++;
    end
    mclk_run = 1'b0;
  endtask

  task automatic resume(input int hp);
    half_p = hp;
    div = 0;
    mclk_run = 1'b1;
  endtask

  task automatic do_reset(input logic lr);
    pause_low();
    @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    exp_q.delete();
    rst_n = 1'b0;
    s_valid = 1'b0;
    m_lr_sel = lr;
    @(negedge clk);
    chk("reset_m_data", m_data, 0);
    chk("reset_m_data_oe", m_data_oe, 0);
    chk("reset_s_ready", s_ready, 0);
    chk("reset_underflow", underflow, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("s_ready_after_release", s_ready, 1);
  endtask

  task automatic push(input logic [15:0] d, input int budget);
    int t = 0;
    @(negedge clk);
    s_data = d;
    s_valid = 1'b1;
    while (!s_ready && t < budget) begin
      @(negedge clk);
      t++;
    end
    chk("push_accepted", s_ready, 1);
    @(posedge clk);
    #1 s_valid = 1'b0;
  endtask

  initial begin
    // Idle silence then 0xC000 / 0x4000, left channel, 40-clk bit clock
    do_reset(1'b0);
    exp_q.push_back(mk(64, 1'b0, 1'b1));
    exp_q.push_back(mk(64, 1'b0, 1'b0));
    exp_q.push_back(mk(96, 1'b0, 1'b0));
    exp_q.push_back(mk(32, 1'b0, 1'b1));
    resume(20);
    wait_bits(128);
    @(negedge clk);
    chk("underflow_after_first_wrap", underflow, 1);
    underflow_clr = 1'b1;
    @(negedge clk);
    underflow_clr = 1'b0;
    chk("underflow_cleared", underflow, 0);
    push(16'hC000, 100);
    push(16'h4000, 100);
    wait_bits(512);

    // Right channel: drive on fall, release on rise
    do_reset(1'b1);
    resume(5);
    wait_bits(16);

    // FIFO fill: fifth sample waits for the first wrap pop
    do_reset(1'b0);
    exp_q.push_back(mk(64, 1'b0, 1'b0));
    exp_q.push_back(mk(16, 1'b0, 1'b0));
    exp_q.push_back(mk(112, 1'b0, 1'b0));
    exp_q.push_back(mk(48, 1'b0, 1'b0));
    exp_q.push_back(mk(80, 1'b0, 1'b0));
    exp_q.push_back(mk(8, 1'b0, 1'b1));
    resume(5);
    push(16'h2000, 100);
    push(16'hE000, 100);
    push(16'h6000, 100);
    push(16'hA000, 100);
    @(negedge clk);
    chk("s_ready_low_when_full", s_ready, 0);
    push(16'h1000, 3000);
    chk("fifth_accepted_after_wrap", (bits >= 128), 1);
    wait_bits(768);

    // Reset mid-window with samples queued: contents discarded, silence restored
    do_reset(1'b0);
    exp_q.push_back(mk(64, 1'b0, 1'b0));
    resume(5);
    for (int i = 0; i < 4; i++) push(16'hC000, 100);
    wait_bits(192);
    do_reset(1'b0);
    exp_q.push_back(mk(64, 1'b0, 1'b1));
    resume(5);
    wait_bits(128);

    pause_low();
    @(negedge clk);
    chk("scoreboard_drained_end", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pdm_mic_emu.md
PDM_MIC_EMU -- requirements
Module: pdm_mic_emu

Interface
REQ-001 SAMPLE_W, 16, PCM sample width; unsigned offset binary (0 = full negative, 2^(SAMPLE_W-1) = silence).
REQ-002 OSR, 128, PDM bits emitted per PCM sample.
REQ-003 FIFO_DEPTH, 4, sample buffer entries; power of two, >=2.
REQ-004 clk  in  1  system clock (100 MHz); sole clock domain.
REQ-005 rst_n  in  1  synchronous, active-low reset.
REQ-006 s_data  in  SAMPLE_W  PCM sample to modulate.
REQ-007 s_valid  in  1  s_data valid.
REQ-008 s_ready  out  1  block accepts s_data this cycle.
REQ-009 m_clk  in  1  PDM bit clock from master; asynchronous to clk; high and low phases each >=4 clk.
REQ-010 m_lr_sel  in  1  channel select: 0 = left, 1 = right.
REQ-011 m_data  out  1  PDM bit stream to master.
REQ-012 m_data_oe  out  1  m_data drive enable (tristate emulation).
REQ-013 underflow  out  1  sticky: sample needed while FIFO empty.
REQ-014 underflow_clr  in  1  clears underflow.

Function
REQ-015 m_clk passes through a 2-FF synchronizer plus a delay register; rise/fall are detected from the last two synchronized values.
REQ-016 Drive edge: detected rise when m_lr_sel=0, detected fall when m_lr_sel=1; release edge is the opposite edge.
REQ-017 On a drive edge, m_data takes the new modulator bit and m_data_oe goes 1 in the same cycle, i.e. 3 clk after the raw m_clk transition.
REQ-018 On a release edge, m_data_oe goes 0; m_data holds its value.
REQ-019 Modulator: first-order accumulator acc of SAMPLE_W bits; on each drive edge {carry, acc} <= acc + cur_sample; emitted bit = carry.
REQ-020 The fraction of 1s emitted over OSR bits equals cur_sample / 2^SAMPLE_W, within +/-1 bit.
REQ-021 A bit counter 0..OSR-1 advances on each drive edge and wraps to 0 after OSR-1.
REQ-022 On the wrap, cur_sample loads the FIFO head, which is popped; the new sample takes effect from the next drive edge.
REQ-023 If the FIFO is empty at the wrap, cur_sample holds its value and underflow sets 1 in the next cycle.
REQ-024 underflow_clr clears underflow; if a set and a clear occur in the same cycle, set wins.
REQ-025 FIFO push when s_valid && s_ready; s_ready = 1 when the FIFO is not full.
REQ-026 Push and pop in the same cycle: FIFO occupancy is unchanged. When the FIFO is empty, a same-cycle push is not bypassed, so the pop takes the underflow path.
REQ-027 A change of m_lr_sel takes effect at the next edge detection; no bit or counter state is reset.
REQ-028 m_clk stopped: all state holds indefinitely.

Reset
REQ-029 While rst_n=0 at a clk edge: m_data=0, m_data_oe=0, s_ready=0, underflow=0, FIFO empty, acc=0, bit counter=0.
REQ-030 At reset, cur_sample = 2^(SAMPLE_W-1), which gives a 50% density (silence).
REQ-031 Synchronizer flops reset to 0; a high m_clk at reset release is seen as a rise.
REQ-032 s_ready rises 1 clk after rst_n deasserts.
REQ-033 Reset during operation discards FIFO contents and the current sample without emitting a partial bit.

Structure
REQ-034 Package pdm_pkg holds the SAMPLE_W and OSR defaults and the silence-value constant, and is shared with the pdm_top receive path.
REQ-035 One sub-module, pdm_sample_fifo: a synchronous FIFO with push, pop, full, empty and data outputs, parameterized by width and depth.

Verification
REQ-036 Reset, m_clk at 2.5 MHz (40 clk period), m_lr_sel=0, no samples -> 64 of 128 bits are 1 per window; underflow=1 after the first wrap.
REQ-037 Push 0xC000, then 0x4000 -> 96 ones in the first window after load, then 32 ones in the next window; m_data changes only 3 clk after m_clk rises.
REQ-038 m_lr_sel=1 -> m_data_oe asserts 3 clk after each m_clk fall and drops 3 clk after each rise.
REQ-039 Push 5 samples back-to-back with DEPTH=4 -> s_ready=0 after 4 accepted; the 5th is accepted only after the first wrap pop; all 5 modulate in order.
REQ-040 Assert rst_n=0 mid-window with 3 samples queued -> outputs reach reset values next clk; after release, density is 50% and underflow=0 until the next wrap.
REQ-041 Loopback into pdm_top with a 16-point sine at 1 kHz -> decimated output tracks the sine; no underflow with a continuous feed.
